// File: rtl/nn_feed_pkg.sv
// Shared constants and types for the NN controller feature feed path.
package nn_feed_pkg;

  localparam int LANES     = 50;
  localparam int FRAME_LEN = 1000;
  localparam int BEATS     = FRAME_LEN / LANES;
  localparam int IDXW      = 5;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    PAD  = 1'b1
  } feed_state_t;

  typedef logic [7:0] lane_t;

endpackage

// File: rtl/beat_skid_reg.sv
// Single output register for a beat (data, index, last) with a valid/ready handshake.
module beat_skid_reg #(
  parameter int DW   = 400,
  parameter int IDXW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [DW-1:0]   s_data,
  input  logic [IDXW-1:0] s_idx,
  input  logic            s_last,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [DW-1:0]   m_data,
  output logic [IDXW-1:0] m_idx,
  output logic            m_last,
  output logic            m_valid,
  input  logic            m_ready
);

  // The register is free when empty or when its current beat leaves this cycle.
  assign s_ready = !m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_idx   <= '0;
      m_last  <= 1'b0;
    end else if (s_ready) begin
      m_valid <= s_valid;
      if (s_valid) begin
        m_data <= s_data;
        m_idx  <= s_idx;
        m_last <= s_last;
      end
    end
  end

endmodule

// File: rtl/feature_beat_packer.sv
// Packs the serial feature byte stream into LANES-byte beats, always BEATS beats per frame.
// Define FEATURE_CHECKSUM_EN to add a per-frame byte checksum reported with the last beat.
module feature_beat_packer #(
  parameter int LANES     = nn_feed_pkg::LANES,
  parameter int FRAME_LEN = nn_feed_pkg::FRAME_LEN,
  parameter int IDXW      = nn_feed_pkg::IDXW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [LANES*8-1:0] m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [IDXW-1:0]    m_idx,
  output logic               m_last,
`ifdef FEATURE_CHECKSUM_EN
  output logic [15:0]        checksum,
  output logic               checksum_valid,
`endif
  output logic               err_len
);

  import nn_feed_pkg::feed_state_t;
  import nn_feed_pkg::FILL;
  import nn_feed_pkg::PAD;

  localparam int BEATS = FRAME_LEN / LANES;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

  feed_state_t        state, state_next;
  logic [LW-1:0]      lane_cnt, lane_cnt_next;
  logic [IDXW-1:0]    fill_beat, fill_beat_next;
  logic [IDXW-1:0]    stage_idx;
  logic [LANES*8-1:0] stage_data;
  logic               stage_full;
  logic               stage_load;
  logic               stage_zero;
  logic               stage_last;
  logic               stage_free;
  logic               out_ready;
  logic               move;
  logic               accept;
  logic               last_lane;
  logic               last_beat;
  logic               frame_end;
  logic               len_err;

  assign last_lane  = (lane_cnt == LW'(LANES - 1));
  assign last_beat  = (fill_beat == IDXW'(BEATS - 1));
  assign stage_last = (stage_idx == IDXW'(BEATS - 1));
  assign move       = stage_full && out_ready;
  assign stage_free = !stage_full || out_ready;

  assign s_ready = !reset && (state == FILL) && stage_free;
  assign accept  = s_valid && s_ready;

  // A frame ends on s_last or on its FRAME_LEN-th byte, whichever comes first;
  // any mismatch between the two is a length error.
  assign frame_end = accept && (s_last || (last_lane && last_beat));
  assign len_err   = accept && (s_last != (last_lane && last_beat));

  always_comb begin
    state_next     = state;
    lane_cnt_next  = lane_cnt;
    fill_beat_next = fill_beat;
    stage_load     = 1'b0;
    stage_zero     = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (last_lane || frame_end) begin
            lane_cnt_next = '0;
            stage_load    = 1'b1;
            if (last_beat) begin
              fill_beat_next = '0;
            end else begin
              fill_beat_next = fill_beat + IDXW'(1);
              if (frame_end) state_next = PAD;
            end
          end else begin
            lane_cnt_next = lane_cnt + LW'(1);
          end
        end
      end
      PAD: begin
        if (stage_free) begin
          stage_load = 1'b1;
          stage_zero = 1'b1;
          if (last_beat) begin
            fill_beat_next = '0;
            state_next     = FILL;
          end else begin
            fill_beat_next = fill_beat + IDXW'(1);
          end
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= FILL;
      lane_cnt   <= '0;
      fill_beat  <= '0;
      stage_full <= 1'b0;
      stage_idx  <= '0;
      err_len    <= 1'b0;
    end else begin
      state      <= state_next;
      lane_cnt   <= lane_cnt_next;
      fill_beat  <= fill_beat_next;
      stage_full <= (stage_full && !move) || stage_load;
      if (stage_load) stage_idx <= fill_beat;
      err_len    <= len_err;
    end
  end

  // A short frame clears the unused upper lanes of its final beat in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || stage_zero) begin
      stage_data <= '0;
    end else if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        if (LW'(k) == lane_cnt) begin
          stage_data[8*k +: 8] <= s_data;
        end else if (frame_end && (LW'(k) > lane_cnt)) begin
          stage_data[8*k +: 8] <= 8'h00;
        end
      end
    end
  end

  beat_skid_reg #(
    .DW   (LANES * 8),
    .IDXW (IDXW)
  ) u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .s_data  (stage_data),
    .s_idx   (stage_idx),
    .s_last  (stage_last),
    .s_valid (stage_full),
    .s_ready (out_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .m_last  (m_last),
    .m_valid (m_valid),
    .m_ready (m_ready)
  );

`ifdef FEATURE_CHECKSUM_EN
  logic [15:0] acc;
  logic [15:0] add_byte;

  assign add_byte       = accept ? {8'h00, s_data} : 16'h0000;
  assign checksum_valid = m_valid && m_ready && m_last;

  // Bytes of the next frame can only be accepted once the final beat leaves the
  // stage, so the sum is snapshotted exactly at that move.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      checksum <= '0;
    end else if (move && stage_last) begin
      checksum <= acc;
      acc      <= add_byte;
    end else begin
      acc <= acc + add_byte;
    end
  end
`endif

endmodule
